// File: rtl/fault_campaign_seq_if.sv
// ============================================================================
// Module  : fault_campaign_seq_if
// Purpose : Bus between the fault-campaign sequencer and the residue-checked
//           adder: operands, residues, fault controls, sum and error flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fault_campaign_seq_if #(
    parameter int NG = 128,
    parameter int W  = 4
);
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [1:0]    A_mod3;
    logic [1:0]    B_mod3;
    logic          Cin;
    logic [NG-1:0] fault_en_bus;
    logic          fault_val;
    logic [W:0]    Sout;
    logic          err;

    modport master (
        output A, B, A_mod3, B_mod3, Cin, fault_en_bus, fault_val,
        input  Sout, err
    );

    modport slave (
        input  A, B, A_mod3, B_mod3, Cin, fault_en_bus, fault_val,
        output Sout, err
    );
endinterface

`default_nettype wire

// File: rtl/fault_campaign_seq.sv
// ============================================================================
// Module  : fault_campaign_seq
// Purpose : Sweeps operands x GID x stuck-at value over a residue-checked
//           adder and classifies each vector into TP/TN/FP/FN counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fault_campaign_seq #(
    parameter int NG         = 128,
    parameter int W          = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16,
    localparam int GW        = (NG > 1) ? $clog2(NG) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             nofault,
    input  wire logic [GW-1:0]    gid_first,
    input  wire logic [GW-1:0]    gid_last,
    fault_campaign_seq_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      tp,
    output logic [CNT_W-1:0]      tn,
    output logic [CNT_W-1:0]      fp,
    output logic [CNT_W-1:0]      fn,
    output logic                  fn_pulse,
    output logic [GW-1:0]         fn_gid,
    output logic                  fn_sa,
    output logic [W-1:0]          fn_a,
    output logic [W-1:0]          fn_b,
    output logic                  fn_any
);

    localparam int             SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [GW-1:0]  GID_MAX     = GW'(NG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [SW-1:0]  settle;
    logic [GW-1:0]  gid;
    logic [GW-1:0]  gid_end;
    logic           sa;
    logic           nf;
    logic [W-1:0]   a;
    logic [W-1:0]   b;

    logic [GW-1:0]  gid_last_clamped;
    logic [W:0]     ref_sum;
    logic           mismatch;
    logic           ab_wrap;
    logic           sa_wrap;
    logic           vec_last;
    logic [W-1:0]   nxt_a;
    logic [W-1:0]   nxt_b;
    logic           nxt_sa;
    logic [GW-1:0]  nxt_gid;

    function automatic logic [1:0] mod3(input logic [W-1:0] v);
        logic [31:0] t;
        t = 32'(v);
        return 2'(t % 32'd3);
    endfunction

    function automatic logic [NG-1:0] onehot(input logic [GW-1:0] g);
        logic [NG-1:0] o;
        o    = '0;
        o[g] = 1'b1;
        return o;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        gid_last_clamped = (gid_last > GID_MAX) ? GID_MAX : gid_last;
        // Carry-in is held at 0, so the reference sum needs no Cin term.
        ref_sum  = {1'b0, a} + {1'b0, b};
        mismatch = (bus.Sout != ref_sum);
        ab_wrap  = (&a) & (&b);
        sa_wrap  = ab_wrap & (nf | sa);
        vec_last = sa_wrap & (nf | (gid == gid_end));
        nxt_b    = b + 1'b1;
        nxt_a    = (&b) ? a + 1'b1 : a;
        nxt_sa   = (ab_wrap & ~nf) ? ~sa : sa;
        nxt_gid  = sa_wrap ? gid + 1'b1 : gid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            settle           <= '0;
            gid              <= '0;
            gid_end          <= '0;
            sa               <= 1'b0;
            nf               <= 1'b0;
            a                <= '0;
            b                <= '0;
            bus.A            <= '0;
            bus.B            <= '0;
            bus.A_mod3       <= '0;
            bus.B_mod3       <= '0;
            bus.Cin          <= 1'b0;
            bus.fault_en_bus <= '0;
            bus.fault_val    <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            tp               <= '0;
            tn               <= '0;
            fp               <= '0;
            fn               <= '0;
            fn_pulse         <= 1'b0;
            fn_gid           <= '0;
            fn_sa            <= 1'b0;
            fn_a             <= '0;
            fn_b             <= '0;
            fn_any           <= 1'b0;
        end else begin
            done     <= 1'b0;
            fn_pulse <= 1'b0;
            bus.Cin  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tp      <= '0;
                        tn      <= '0;
                        fp      <= '0;
                        fn      <= '0;
                        fn_any  <= 1'b0;
                        nf      <= nofault;
                        gid_end <= gid_last_clamped;
                        if (!nofault && (gid_first > gid_last_clamped)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            gid              <= gid_first;
                            sa               <= 1'b0;
                            a                <= '0;
                            b                <= '0;
                            settle           <= '0;
                            bus.A            <= '0;
                            bus.B            <= '0;
                            bus.A_mod3       <= 2'd0;
                            bus.B_mod3       <= 2'd0;
                            bus.fault_en_bus <= nofault ? '0 : onehot(gid_first);
                            bus.fault_val    <= 1'b0;
                            busy             <= 1'b1;
                            state            <= DRIVE;
                        end
                    end
                end

                DRIVE: begin
                    if (settle == SETTLE_LAST) begin
                        settle <= '0;
                        state  <= CHECK;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end

                CHECK: begin
                    if (mismatch && bus.err) begin
                        tp <= sat_inc(tp);
                    end else if (mismatch) begin
                        fn       <= sat_inc(fn);
                        fn_pulse <= 1'b1;
                        fn_gid   <= gid;
                        fn_sa    <= sa;
                        fn_a     <= a;
                        fn_b     <= b;
                        fn_any   <= 1'b1;
                    end else if (bus.err) begin
                        fp <= sat_inc(fp);
                    end else begin
                        tn <= sat_inc(tn);
                    end

                    if (vec_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        a                <= nxt_a;
                        b                <= nxt_b;
                        sa               <= nxt_sa;
                        gid              <= nxt_gid;
                        bus.A            <= nxt_a;
                        bus.B            <= nxt_b;
                        bus.A_mod3       <= mod3(nxt_a);
                        bus.B_mod3       <= mod3(nxt_b);
                        bus.fault_en_bus <= nf ? '0 : onehot(nxt_gid);
                        bus.fault_val    <= nf ? 1'b0 : nxt_sa;
                        state            <= DRIVE;
                    end
                end

                DONE: begin
                    bus.fault_en_bus <= '0;
                    bus.fault_val    <= 1'b0;
                    state            <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
